// File: rtl/sram_pkg.sv
// Shared types for the SRAM controller slice: controller phase encoding and
// the write-slot payload.
package sram_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [2:0] {
    PH_WAIT,
    PH_W1,
    PH_W2,
    PH_R1,
    PH_R2
  } sram_phase_t;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] data;
  } sram_wr_t;

endpackage

// File: rtl/sram_slot_tracker.sv
// Mirrors the SRAM controller's fixed schedule and flags the cycle before
// each Write_1 so that upstream logic can load the controller's inputs.
module sram_slot_tracker
  import sram_pkg::*;
(
  input  logic       clock_100,
  input  logic       reset,
  output logic [2:0] phase,
  output logic       load
);

  sram_phase_t state, state_next;

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) state <= PH_WAIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PH_WAIT: state_next = PH_W1;
      PH_W1:   state_next = PH_W2;
      PH_W2:   state_next = PH_R1;
      PH_R1:   state_next = PH_R2;
      PH_R2:   state_next = PH_W1;
      default: state_next = PH_WAIT;
    endcase
  end

  // WAIT and R2 both precede a W1, so both are load cycles.
  always_comb begin
    phase = state;
    load  = 1'b0;
    if (state == PH_WAIT || state == PH_R2) load = 1'b1;
  end

endmodule

// File: rtl/sram_write_queue.sv
// Pixel write FIFO feeding the SRAM controller's write slot: one write per
// 4-cycle round, outputs held stable from W1 through R2.
module sram_write_queue
  import sram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = SRAM_AW,
  parameter int DW    = SRAM_DW
) (
  input  logic                   clock_100,
  input  logic                   reset,
  input  logic                   px_valid,
  output logic                   px_ready,
  input  logic [AW-1:0]          px_addr,
  input  logic [DW-1:0]          px_data,
  output logic                   write_enable,
  output logic [AW-1:0]          write_addr,
  output logic [DW-1:0]          write_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  // Handshake: a pixel transfers on any edge where px_valid && px_ready;
  // px_valid may be held while px_ready is low and nothing is taken.
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [2:0]    slot_phase;
  logic          load, push, pop;

  sram_slot_tracker u_tracker (
    .clock_100 (clock_100),
    .reset     (reset),
    .phase     (slot_phase),
    .load      (load)
  );

  assign px_ready = (count != LW'(DEPTH));
  assign push     = px_valid && px_ready;
  assign pop      = load && (count != '0);
  assign level    = count;
  assign idle     = (count == '0) && !write_enable;

  always_ff @(posedge clock_100) begin
    if (push) mem[wr_ptr] <= {px_addr, px_data};
  end

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs only move on load edges; an empty queue on a load edge idles
  // the round but keeps the last address/data on the bus.
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (load) begin
      if (count != '0) begin
        write_enable <= 1'b1;
        write_addr   <= mem[rd_ptr].addr;
        write_data   <= mem[rd_ptr].data;
      end else begin
        write_enable <= 1'b0;
      end
    end
  end

  load_matches_phase: assert property (@(posedge clock_100) disable iff (!reset)
    load == (slot_phase == PH_WAIT || slot_phase == PH_R2));

endmodule

// File: tb/tb_sram_write_queue.sv
// Directed and randomised checks of sram_write_queue against a cycle model
// of the slot schedule and FIFO.
module tb_sram_write_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 20;
  localparam int DW    = 16;

  logic          clock_100 = 1'b0;
  logic          reset     = 1'b0;
  logic          px_valid  = 1'b0;
  logic [AW-1:0] px_addr   = '0;
  logic [DW-1:0] px_data   = '0;
  logic          px_ready, write_enable, idle;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [4:0]    level;

  sram_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock_100    (clock_100),
    .reset        (reset),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_addr      (px_addr),
    .px_data      (px_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .level        (level),
    .idle         (idle)
  );

  always #5 clock_100 = ~clock_100;

  // scoreboard / reference model
  int                  n_vec = 0;
  int                  n_err = 0;
  logic [AW+DW-1:0]    exp_q[$];
  logic                m_we;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_data;
  int                  m_cyc;
  int                  max_lvl = 0;

  task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, obs, exp_v, $time, m_cyc);
    end
  endtask

  task automatic compare_all();
    check_val("level", 40'(level), 40'(exp_q.size()));
    check_val("px_ready", 40'(px_ready), 40'(exp_q.size() != DEPTH));
    check_val("write_enable", 40'(write_enable), 40'(m_we));
    check_val("write_addr", 40'(write_addr), 40'(m_addr));
    check_val("write_data", 40'(write_data), 40'(m_data));
    check_val("idle", 40'(idle), 40'(exp_q.size() == 0 && !m_we));
    check_val("load", 40'(dut.load), 40'(m_cyc % 4 == 0));
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  // Advance one clock: model the edge, then sample 1 time unit after it.
  task automatic tick(output bit acc);
    int pre;
    pre = exp_q.size();
    acc = px_valid && (pre != DEPTH);
    if (m_cyc % 4 == 0) begin
      if (pre > 0) begin
        {m_addr, m_data} = exp_q.pop_front();
        m_we = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end
    if (acc) exp_q.push_back({px_addr, px_data});
    @(posedge clock_100);
    #1;
    m_cyc++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    bit a;
    for (int k = 0; k < n; k++) tick(a);
  endtask

  // Asynchronous reset from mid-cycle; released one unit after an edge.
  task automatic reset_dut();
    reset    = 1'b0;
    px_valid = 1'b0;
    #1;
    exp_q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cyc  = 0;
    check_val("rst_we", 40'(write_enable), 40'h0);
    check_val("rst_level", 40'(level), 40'h0);
    compare_all();
    repeat (2) @(posedge clock_100);
    #1;
    reset = 1'b1;
    compare_all();
  endtask

  initial begin
    bit acc;
    int i;
    bit seen_full_load;

    // power-on reset
    exp_q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_cyc = 0;
    repeat (3) @(posedge clock_100);
    #1;
    reset = 1'b1;
    compare_all();

    // 1: idle schedule
    ticks(20);
    check_val("t1_idle", 40'(idle), 40'h1);

    // 2: single push at cycle 2; visible W1..R2 of the next round
    reset_dut();
    ticks(2);
    px_valid = 1'b1; px_addr = 20'h00123; px_data = 16'hBEEF;
    tick(acc);
    check_val("t2_accept", 40'(acc), 40'h1);
    px_valid = 1'b0;
    ticks(2);
    check_val("t2_we_w1", 40'(write_enable), 40'h1);
    check_val("t2_addr", 40'(write_addr), 40'h00123);
    check_val("t2_data", 40'(write_data), 40'hBEEF);
    check_val("t2_level", 40'(level), 40'h0);
    ticks(3);
    check_val("t2_we_r2", 40'(write_enable), 40'h1);
    ticks(1);
    check_val("t2_we_after", 40'(write_enable), 40'h0);
    check_val("t2_idle", 40'(idle), 40'h1);

    // 3/4: burst until full with the push held across load edges
    reset_dut();
    ticks(1);
    px_valid = 1'b1;
    i = 0;
    seen_full_load = 1'b0;
    max_lvl = 0;
    for (int c = 0; c < 40; c++) begin
      px_addr = 20'(i);
      px_data = ~16'(i);
      if (!seen_full_load && exp_q.size() == DEPTH && m_cyc % 4 == 0) begin
        seen_full_load = 1'b1;
        tick(acc);
        check_val("t4_no_push_on_full", 40'(acc), 40'h0);
        check_val("t4_ready_after_pop", 40'(px_ready), 40'h1);
        check_val("t4_level_after_pop", 40'(level), 40'd15);
        tick(acc);
        check_val("t4_push_next_cycle", 40'(acc), 40'h1);
        check_val("t4_level_refill", 40'(level), 40'd16);
        if (acc) i++;
        px_addr = 20'(i);
        px_data = ~16'(i);
      end
      tick(acc);
      if (acc) i++;
    end
    check_val("t4_saw_full_load", 40'(seen_full_load), 40'h1);
    px_valid = 1'b0;
    ticks(80);
    check_val("t3_max_level", 40'(max_lvl), 40'd16);
    check_val("t3_drained", 40'(level), 40'h0);

    // 5: reset with five queued while in W2
    reset_dut();
    px_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      px_addr = 20'h100 + 20'(k);
      px_data = 16'hA000 + 16'(k);
      tick(acc);
    end
    px_valid = 1'b0;
    check_val("t5_level_pre", 40'(level), 40'd5);
    check_val("t5_we_pre", 40'(write_enable), 40'h1);
    check_val("t5_addr_pre", 40'(write_addr), 40'h100);
    reset_dut();
    ticks(1);
    check_val("t5_first_w1_empty", 40'(write_enable), 40'h0);

    // 6: random traffic against the model, duplicate addresses included
    reset_dut();
    for (int c = 0; c < 10000; c++) begin
      px_valid = ($urandom_range(0, 99) < 45);
      px_addr  = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 3))
                                             : 20'($urandom_range(0, 20'hFFFFF));
      px_data  = 16'($urandom_range(0, 16'hFFFF));
      tick(acc);
    end
    px_valid = 1'b0;
    ticks(80);
    check_val("t6_drained", 40'(level), 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
